// File: rtl/ahb_onchip_sram_pkg.sv
// Shared encodings, FSM states and byte-lane helper for the AHB on-chip SRAM slave.
package ahb_onchip_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_ADDR,
    ST_WRITE,
    ST_RD_WAIT,
    ST_RD_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Lane enables for a transfer of the given size at the given byte offset.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lsb);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << lsb;
      HSIZE_HALF: be = lsb[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_onchip_sram_bank.sv
// Synchronous single-port SRAM bank with byte-lane write enables and registered read data.
module sram_bank #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              wen,
  input  logic [DW/8-1:0]   byte_en,
  input  logic [AW-1:0]     addr,
  input  logic [DW-1:0]     wdata,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Lane-masked write, or registered read that otherwise holds its last value.
  always_ff @(posedge clk) begin
    if (en) begin
      if (wen) begin
        for (int unsigned i = 0; i < DW/8; i++) begin
          if (byte_en[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/ahb_onchip_sram.sv
// AHB-Lite slave in front of N_SRAM single-port SRAM banks: zero-wait writes,
// one-wait reads, two-cycle ERROR for illegal accesses.
module ahb_onchip_sram
  import ahb_onchip_sram_pkg::*;
#(
  parameter int unsigned N_SRAM     = 1,
  parameter int unsigned SRAM_WIDTH = 4,
  parameter int unsigned SRAM_DEPTH = 1024
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);

  localparam int unsigned DW        = 8 * SRAM_WIDTH;
  localparam int unsigned BE_W      = SRAM_WIDTH;
  localparam int unsigned ROW_W     = (SRAM_DEPTH > 1) ? $clog2(SRAM_DEPTH) : 1;
  localparam int unsigned BANK_W    = (N_SRAM > 1) ? $clog2(N_SRAM) : 1;
  localparam longint unsigned MEM_BYTES = 64'(SRAM_WIDTH) * 64'(N_SRAM) * 64'(SRAM_DEPTH);

  state_e state_q, state_d;
  logic   hready_d, hresp_d;

  logic              active, accept, legal, misaligned, in_range;
  logic [31:0]       word_idx;
  logic [BANK_W-1:0] bank_q;
  logic [ROW_W-1:0]  row_q;
  logic [BE_W-1:0]   be_q;

  logic              sram_en, sram_wen;
  logic [N_SRAM-1:0] bank_en;
  logic [DW-1:0]     bank_rdata [N_SRAM];
  logic [DW-1:0]     rdata_mux, hold_q;

  // Burst type carries no information for this slave; every beat stands alone.
  logic unused_hburst;
  assign unused_hburst = ^HBURST;

  // Transfer-type decode.
  always_comb begin
    active = 1'b0;
    case (HTRANS)
      HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
      default:                   active = 1'b0;
    endcase
  end

  assign accept     = HSEL && HREADY && active;
  assign misaligned = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                      ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
  assign in_range   = 64'(HADDR) < MEM_BYTES;
  assign legal      = (HSIZE <= HSIZE_WORD) && !misaligned && in_range;
  assign word_idx   = {2'b00, HADDR[31:2]};

  // Next state, SRAM strobes and next response values.
  always_comb begin
    state_d  = state_q;
    sram_en  = 1'b0;
    sram_wen = 1'b0;
    case (state_q)
      ST_RD_WAIT: state_d = ST_RD_DATA;
      ST_ERR1:    state_d = ST_ERR2;
      default: begin
        if (!accept)     state_d = ST_ADDR;
        else if (!legal) state_d = ST_ERR1;
        else if (HWRITE) state_d = ST_WRITE;
        else             state_d = ST_RD_WAIT;
      end
    endcase
    if (state_q == ST_WRITE) begin
      sram_en  = 1'b1;
      sram_wen = 1'b1;
    end
    if (state_q == ST_RD_WAIT) begin
      sram_en = 1'b1;
    end
    hready_d = !((state_d == ST_RD_WAIT) || (state_d == ST_ERR1));
    hresp_d  = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  end

  // State and registered bus response.
  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      state_q <= ST_ADDR;
      HREADY  <= 1'b1;
      HRESP   <= HRESP_OKAY;
    end else begin
      state_q <= state_d;
      HREADY  <= hready_d;
      HRESP   <= hresp_d;
    end
  end

  // Capture bank/row/lanes of an accepted legal address phase.
  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      bank_q <= '0;
      row_q  <= '0;
      be_q   <= '0;
    end else if (accept && legal) begin
      bank_q <= BANK_W'(word_idx / SRAM_DEPTH);
      row_q  <= ROW_W'(word_idx % SRAM_DEPTH);
      be_q   <= BE_W'(byte_en(HSIZE, HADDR[1:0]));
    end
  end

  // Bank array; only the addressed bank is strobed.
  for (genvar b = 0; b < N_SRAM; b++) begin : g_bank
    assign bank_en[b] = sram_en && (bank_q == BANK_W'(b));
    sram_bank #(
      .DEPTH (SRAM_DEPTH),
      .AW    (ROW_W),
      .DW    (DW)
    ) u_bank (
      .clk     (HCLK),
      .en      (bank_en[b]),
      .wen     (sram_wen),
      .byte_en (be_q),
      .addr    (row_q),
      .wdata   (HWDATA),
      .rdata   (bank_rdata[b])
    );
  end

  // Read-data select from the bank addressed by the current transfer.
  always_comb begin
    rdata_mux = '0;
    for (int unsigned b = 0; b < N_SRAM; b++) begin
      if (bank_q == BANK_W'(b)) rdata_mux = bank_rdata[b];
    end
  end

  // Keep the last returned word so HRDATA is stable outside read data phases.
  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      hold_q <= '0;
    end else if (state_q == ST_RD_DATA) begin
      hold_q <= rdata_mux;
    end
  end

  // Fresh SRAM word during the read data cycle, held word otherwise.
  assign HRDATA = (state_q == ST_RD_DATA) ? rdata_mux : hold_q;

endmodule

// File: tb/tb_ahb_onchip_sram.sv
// Self-checking bench for ahb_onchip_sram against a byte-array memory model.
module tb_ahb_onchip_sram;

  localparam int unsigned N_SRAM     = 1;
  localparam int unsigned SRAM_WIDTH = 4;
  localparam int unsigned SRAM_DEPTH = 1024;
  localparam int unsigned MEM_BYTES  = 4 * N_SRAM * SRAM_DEPTH;

  logic        HCLK = 1'b0;
  logic        HRESETn, HSEL, HWRITE;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic        HREADY, HRESP;

  always #5 HCLK = ~HCLK;

  ahb_onchip_sram #(
    .N_SRAM     (N_SRAM),
    .SRAM_WIDTH (SRAM_WIDTH),
    .SRAM_DEPTH (SRAM_DEPTH)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .HSEL    (HSEL),
    .HADDR   (HADDR),
    .HTRANS  (HTRANS),
    .HWRITE  (HWRITE),
    .HSIZE   (HSIZE),
    .HBURST  (HBURST),
    .HWDATA  (HWDATA),
    .HRDATA  (HRDATA),
    .HREADY  (HREADY),
    .HRESP   (HRESP)
  );

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  burst;
  } op_t;

  op_t         op_q[$];
  logic [7:0]  mem_model [MEM_BYTES];
  logic [31:0] last_rd;
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;

  op_t ap_op, dp_op;
  bit  ap_pending = 0;
  bit  dp_valid   = 0;
  int  dp_cycle   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic op_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                             input logic [2:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata);
    op_t o;
    o.sel = sel; o.trans = trans; o.wr = wr; o.size = size;
    o.addr = addr; o.wdata = wdata; o.burst = 3'd0;
    return o;
  endfunction

  // Reference rules: a transfer exists for NONSEQ/SEQ with HSEL; it is legal when
  // naturally aligned, at most a word wide, and inside the memory.
  function automatic bit is_active(input op_t o);
    return o.sel && (o.trans == 2'd2 || o.trans == 2'd3);
  endfunction

  function automatic bit is_legal(input op_t o);
    return (o.size <= 3'd2) && ((o.addr % (32'd1 << o.size)) == 0) && (o.addr < MEM_BYTES);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int unsigned base;
    base = addr - (addr % 4);
    return {mem_model[base+3], mem_model[base+2], mem_model[base+1], mem_model[base]};
  endfunction

  task automatic model_write(input op_t o);
    int unsigned a;
    for (int unsigned i = 0; i < (32'd1 << o.size); i++) begin
      a = o.addr + i;
      mem_model[a] = o.wdata[8*(a%4) +: 8];
    end
  endtask

  task automatic drive_op(input op_t o);
    HSEL = o.sel; HTRANS = o.trans; HWRITE = o.wr; HSIZE = o.size;
    HADDR = o.addr; HBURST = o.burst;
  endtask

  task automatic drive_idle();
    HSEL = 1'b0; HTRANS = 2'd0; HWRITE = 1'b0; HSIZE = 3'd0; HADDR = '0; HBURST = 3'd0;
  endtask

  function automatic op_t rand_op();
    op_t         o;
    int unsigned k;
    k = $urandom_range(0, 19);
    o.sel = (k != 0);
    if (k == 1)      o.trans = 2'd0;
    else if (k == 2) o.trans = 2'd1;
    else             o.trans = 2'($urandom_range(2, 3));
    o.wr = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 15) == 0) o.size = 3'($urandom_range(3, 7));
    else                            o.size = 3'($urandom_range(0, 2));
    if ($urandom_range(0, 11) == 0) begin
      o.addr = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(MEM_BYTES, MEM_BYTES + 64));
    end else begin
      o.addr = 32'($urandom_range(0, MEM_BYTES - 1));
      if ($urandom_range(0, 4) != 0 && o.size <= 3'd2)
        o.addr = o.addr - (o.addr % (32'd1 << o.size));
    end
    o.wdata = $urandom();
    o.burst = 3'($urandom_range(0, 7));
    return o;
  endfunction

  // One bus cycle: check the running data phase, then drive the next address phase
  // (or junk while the slave is stalling, which it must ignore).
  task automatic step();
    logic        r, lg, exp_ready, exp_resp;
    logic [31:0] exp_data;
    int          waits;
    @(negedge HCLK);
    cyc++;
    if (ap_pending) begin
      dp_op      = ap_op;
      dp_valid   = is_active(ap_op);
      dp_cycle   = 0;
      ap_pending = 0;
    end
    r  = HREADY;
    lg = 1'b0;
    if (dp_valid) begin
      dp_cycle++;
      lg        = is_legal(dp_op);
      waits     = (lg && dp_op.wr) ? 0 : 1;
      exp_ready = (dp_cycle > waits);
      exp_resp  = !lg;
      exp_data  = (lg && !dp_op.wr && exp_ready) ? model_read(dp_op.addr) : last_rd;
    end else begin
      exp_ready = 1'b1;
      exp_resp  = 1'b0;
      exp_data  = last_rd;
    end
    chk("hready", 32'(HREADY), 32'(exp_ready));
    chk("hresp",  32'(HRESP),  32'(exp_resp));
    chk("hrdata", HRDATA, exp_data);
    if (dp_valid && dp_cycle > 4) begin
      errors++;
      $display("FAIL stuck_data_phase: HREADY %b after %0d cycles, required 1", HREADY, dp_cycle);
      $fatal(1, "data phase never completed");
    end
    HWDATA = (dp_valid && dp_op.wr) ? dp_op.wdata : $urandom();
    if (r) begin
      if (dp_valid) begin
        if (lg && dp_op.wr)  model_write(dp_op);
        if (lg && !dp_op.wr) last_rd = model_read(dp_op.addr);
        dp_valid = 0;
      end
      if (op_q.size() != 0) begin
        ap_op      = op_q.pop_front();
        ap_pending = 1;
        drive_op(ap_op);
      end else begin
        drive_idle();
      end
    end else begin
      HSEL = 1'b1; HTRANS = 2'd2; HWRITE = 1'($urandom_range(0, 1));
      HSIZE = 3'($urandom_range(0, 2)); HADDR = 32'($urandom_range(0, MEM_BYTES - 1));
    end
  endtask

  task automatic run_queue();
    int budget;
    budget = 8 * op_q.size() + 50;
    while (op_q.size() != 0 || ap_pending || dp_valid) begin
      step();
      budget--;
      if (budget == 0) begin
        errors++;
        $display("FAIL run_budget: queue not drained, %0d ops left", op_q.size());
        $fatal(1, "bus sequence exceeded cycle budget");
      end
    end
  endtask

  // Start a transfer, hit reset in its stall cycle, and check the abort.
  task automatic reset_mid(input op_t o, input string tag);
    @(negedge HCLK);
    drive_op(o);
    @(negedge HCLK);
    drive_idle();
    chk({tag, "_stall"}, 32'(HREADY), 32'd0);
    HRESETn = 1'b1;
    #1;
    chk({tag, "_rst_hready"}, 32'(HREADY), 32'd1);
    chk({tag, "_rst_hresp"},  32'(HRESP),  32'd0);
    chk({tag, "_rst_hrdata"}, HRDATA, 32'd0);
    @(negedge HCLK);
    HRESETn    = 1'b0;
    last_rd    = '0;
    dp_valid   = 0;
    ap_pending = 0;
  endtask

  initial begin
    HRESETn = 1'b1;
    HWDATA  = '0;
    last_rd = '0;
    drive_idle();
    repeat (2) @(negedge HCLK);
    chk("reset_hready", 32'(HREADY), 32'd1);
    chk("reset_hresp",  32'(HRESP),  32'd0);
    chk("reset_hrdata", HRDATA, 32'd0);
    HRESETn = 1'b0;

    // Define every word so later reads have known contents; back-to-back writes.
    for (int unsigned w = 0; w < MEM_BYTES / 4; w++)
      op_q.push_back(mk(1'b1, 2'd2, 1'b1, 3'd2, 32'(4 * w), $urandom()));
    run_queue();

    op_q.push_back(mk(1'b1, 2'd2, 1'b1, 3'd2, 32'h0, 32'hDEADBEEF));
    op_q.push_back(mk(1'b1, 2'd2, 1'b0, 3'd2, 32'h0, 32'h0));
    run_queue();
    chk("word_rw", HRDATA, 32'hDEADBEEF);

    op_q.push_back(mk(1'b1, 2'd2, 1'b1, 3'd2, 32'h4, 32'h11223344));
    op_q.push_back(mk(1'b1, 2'd3, 1'b1, 3'd0, 32'h5, 32'h0000AA00));
    op_q.push_back(mk(1'b1, 2'd2, 1'b0, 3'd2, 32'h4, 32'h0));
    run_queue();
    chk("byte_merge", HRDATA, 32'h1122AA44);

    op_q.push_back(mk(1'b1, 2'd2, 1'b1, 3'd2, 32'h8, 32'hCAFE1234));
    op_q.push_back(mk(1'b1, 2'd2, 1'b1, 3'd1, 32'hA, 32'hBEEF0000));
    op_q.push_back(mk(1'b1, 2'd2, 1'b0, 3'd2, 32'h8, 32'h0));
    run_queue();
    chk("half_merge", HRDATA, 32'hBEEF1234);

    op_q.push_back(mk(1'b1, 2'd2, 1'b0, 3'd2, 32'h2, 32'h0));
    op_q.push_back(mk(1'b1, 2'd2, 1'b1, 3'd2, 32'h1000, 32'h55555555));
    op_q.push_back(mk(1'b1, 2'd2, 1'b0, 3'd2, 32'h0, 32'h0));
    run_queue();
    chk("after_error", HRDATA, 32'hDEADBEEF);

    op_q.push_back(mk(1'b1, 2'd0, 1'b1, 3'd2, 32'h0, 32'h0));
    op_q.push_back(mk(1'b1, 2'd1, 1'b1, 3'd2, 32'h0, 32'h0));
    op_q.push_back(mk(1'b0, 2'd2, 1'b1, 3'd2, 32'h0, 32'h0));
    op_q.push_back(mk(1'b1, 2'd2, 1'b0, 3'd2, 32'h0, 32'h0));
    run_queue();
    chk("after_idle", HRDATA, 32'hDEADBEEF);

    op_q.push_back(mk(1'b1, 2'd2, 1'b1, 3'd2, MEM_BYTES - 4, 32'h0BADF00D));
    op_q.push_back(mk(1'b1, 2'd2, 1'b1, 3'd0, MEM_BYTES, 32'hFFFFFFFF));
    op_q.push_back(mk(1'b1, 2'd2, 1'b1, 3'd0, MEM_BYTES - 1, 32'h77000000));
    op_q.push_back(mk(1'b1, 2'd2, 1'b0, 3'd2, MEM_BYTES - 4, 32'h0));
    run_queue();
    chk("top_word", HRDATA, 32'h77ADF00D);

    op_q.push_back(mk(1'b1, 2'd2, 1'b1, 3'd2, 32'h40, 32'h5A5A1234));
    run_queue();
    reset_mid(mk(1'b1, 2'd2, 1'b0, 3'd2, 32'h40, 32'h0), "rst_read");
    op_q.push_back(mk(1'b1, 2'd2, 1'b0, 3'd2, 32'h40, 32'h0));
    run_queue();
    chk("read_after_rst", HRDATA, 32'h5A5A1234);
    reset_mid(mk(1'b1, 2'd2, 1'b1, 3'd3, 32'h40, 32'h0), "rst_err");
    op_q.push_back(mk(1'b1, 2'd2, 1'b0, 3'd2, 32'h40, 32'h0));
    run_queue();
    chk("read_after_rst_err", HRDATA, 32'h5A5A1234);

    for (int i = 0; i < 600; i++) op_q.push_back(rand_op());
    run_queue();

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_onchip_sram.md
# ahb_onchip_sram

AHB-Lite slave that fronts an on-chip, synchronous, single-port SRAM with byte enables. It sits on the system AHB bus behind the address decoder (HSEL) and serves byte, halfword and word reads and writes. Writes complete with zero wait states. Reads take one wait state. Illegal accesses get a two-cycle ERROR response.

## Interface
Parameters:
- N_SRAM, 1: number of SRAM banks; total capacity is N_SRAM*SRAM_DEPTH words.
- SRAM_WIDTH, 4: bank word width in bytes. Only 4 is supported (32-bit bus).
- SRAM_DEPTH, 1024: words per bank.

Ports (one clock; reset is asynchronous and active-high):
- HCLK  in  1  system clock; all state changes on its rising edge.
- HRESETn  in  1  asynchronous reset, active-high; the name is kept to match the codebase.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address, offset from 0.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = halfword, 2 = word.
- HBURST  in  3  accepted and ignored; every beat is decoded independently.
- HWDATA  in  32  write data, valid in the data phase.
- HRDATA  out  32  read data, little-endian lanes.
- HREADY  out  1  transfer done (HREADYOUT).
- HRESP  out  1  0 = OKAY, 1 = ERROR.

## Operation
- Address phase is accepted when HSEL=1, HTRANS is NONSEQ or SEQ, and HREADY=1. The block registers addr, size, write and a legal flag.
- IDLE, BUSY or HSEL=0: the next data phase is zero-wait OKAY and the memory is untouched.
- An access is illegal when any of the following holds:
  - HSIZE>2;
  - halfword with HADDR[0]=1;
  - word with HADDR[1:0]≠0;
  - HADDR ≥ 4*N_SRAM*SRAM_DEPTH.
- Decode: word index = HADDR>>2; bank = index/SRAM_DEPTH; row = index%SRAM_DEPTH.
- Byte enables:
  - byte: bit HADDR[1:0];
  - halfword: 0011 or 1100;
  - word: 1111.
- Write: at the end of the data phase, the enabled lanes of HWDATA are written to the bank/row. Other lanes are unchanged.
- Read: in the first data-phase cycle the SRAM is enabled with the row. The full 32-bit word is driven on HRDATA in the second cycle. The master selects lanes.
- HRDATA holds its last read value otherwise.
- FSM states and transitions:
  - ADDR (idle or accepting an address): legal write → WRITE; legal read → RD_WAIT; illegal → ERR1.
  - WRITE (HREADY=1): performs the write and accepts the next address phase.
  - RD_WAIT (HREADY=0, SRAM read issued) → RD_DATA.
  - RD_DATA (HREADY=1, HRDATA valid): accepts the next address phase.
  - ERR1 (HREADY=0, HRESP=1) → ERR2.
  - ERR2 (HREADY=1, HRESP=1): accepts the next address phase.
- Write followed by read of the same address returns the new data; there is no hazard because the port is single and accesses are serialized.
- Memory contents are not reset.

## Timing
- Reset values: HREADY=1, HRESP=0, HRDATA=0, FSM=ADDR. Any pending write is dropped.
- Write latency: 1 data-phase cycle. Memory is updated at the rising edge that ends the data phase.
- Read latency: 2 data-phase cycles (1 wait state). Back-to-back reads sustain 1 word per 2 cycles.
- Error: exactly 2 cycles. HRESP=1 in both cycles, HREADY 0 then 1. Memory is unchanged.
- Address phases are sampled only when HREADY=1. Address-phase inputs during wait cycles are ignored.
- Reset asserted mid-read or mid-error aborts the transfer. The cycle after release is ADDR with HREADY=1.

## Structure
- Package ahb_onchip_sram_pkg holds:
  - HTRANS, HSIZE and HRESP encodings;
  - the FSM state enum;
  - a byte-enable function of (size, addr[1:0]).
- Sub-module sram_bank: synchronous single-port SRAM, SRAM_DEPTH x 32, with en, wen, byte_en[3:0], addr, wdata and registered rdata. It is instantiated N_SRAM times.
- Top level contains the AHB FSM, decode, bank mux and response logic.

## Test plan
- Write word 0xDEADBEEF to 0x0, then read 0x0 → write has HREADY=1 with no wait; read has 1 wait cycle, then HRDATA=0xDEADBEEF, HRESP=0.
- Byte write 0xAA to 0x5 over word 0x11223344 at 0x4 → read of 0x4 returns 0x1122AA44.
- Halfword write 0xBEEF to 0xA, then read 0x8 → upper half is 0xBEEF and the lower half is unchanged.
- Word read at 0x2, and word write to 0x1000 (depth 1024, N_SRAM=1) → ERR1 then ERR2 with HRESP=1; a later read of 0x0 is unchanged.
- IDLE and BUSY transfers, and HSEL=0 with HTRANS=NONSEQ → HREADY=1, HRESP=0, memory unchanged.
- Assert HRESETn during RD_WAIT → HREADY=1 and HRESP=0 immediately; the next read of a prior-written address returns its data.
